// File: rtl/md_defs.sv
// ---------------------------------------------------------------------------
// md_defs
// Shared definitions for the multiply/divide unit: default operand width,
// iteration counter width, MD operation encodings and the FSM state
// encodings used by md_unit.
// ---------------------------------------------------------------------------
package md_defs;

  // Default operand / HI / LO width and the counter width that must be able
  // to hold (WIDTH - 1).
  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 5;

  // MD operation codes as presented on the op input. 3'b110 and 3'b111 are
  // not listed on purpose: the unit treats them as no-ops.
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  // Control FSM states.
  //   ST_IDLE : ready to accept a new operation
  //   ST_RUN  : divider iterating, pipeline stalled
  //   ST_FIX  : sign correction and HI/LO write-back of a division
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// ---------------------------------------------------------------------------
// md_div_core
// Iterative unsigned restoring divider datapath. One quotient bit is
// produced per step, MSB first, so a full division takes `width` steps.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load dividend/divisor and clear the step counter
//   step        : perform one shift-subtract iteration this cycle
//   dividend    : unsigned dividend, sampled on start
//   divisor     : unsigned divisor, sampled on start
//   done        : high during the step that produces the final quotient bit
//   quotient    : current quotient shift register
//   remainder   : current partial remainder
// ---------------------------------------------------------------------------
module md_div_core
  import md_defs::*;
#(
  parameter int width    = WIDTH,
  parameter int CntWidth = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
  output logic             done,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder
);

  logic [width-1:0]    rem_q;
  logic [width-1:0]    quo_q;
  logic [width-1:0]    dvs_q;
  logic [CntWidth-1:0] cnt_q;

  // The dividend lives in the quotient register and is shifted out MSB
  // first into the partial remainder while quotient bits shift in at the
  // bottom. The subtraction is one bit wider than the operands so its MSB
  // acts as the borrow: set means the divisor did not fit this step.
  logic [width:0] shifted;
  logic [width:0] diff;

  assign shifted = {rem_q, quo_q[width-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  assign done      = step && (cnt_q == CntWidth'(width - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Operand load on start, one restoring iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CntWidth'(1);
      if (!diff[width]) begin
        rem_q <= diff[width-1:0];
        quo_q <= {quo_q[width-2:0], 1'b1};
      end else begin
        rem_q <= shifted[width-1:0];
        quo_q <= {quo_q[width-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// EX-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU and MTHI/MTLO complete in the accept cycle; DIV/DIVU run on
// md_div_core for `width` cycles followed by one FIX cycle that applies the
// sign correction and writes HI/LO.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : valid MD instruction in EX this cycle
//   op         : operation code (see md_defs::md_op_e)
//   src_a      : rs value (dividend, multiplicand, MT source)
//   src_b      : rt value (divisor, multiplier)
//   cancel     : exception flush, aborts in-flight / presented operation
//   busy       : stall request to the hazard unit
//   hi, lo     : HI and LO registers
// ---------------------------------------------------------------------------
module md_unit
  import md_defs::*;
#(
  parameter int width    = WIDTH,
  parameter int CntWidth = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [width-1:0] src_a,
  input  logic [width-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo
);

  md_state_e state_q;
  md_state_e state_d;

  logic accept;
  logic is_div_op;
  logic is_signed_div;

  // Division context captured at accept time and consumed in FIX.
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             div_zero_q;
  logic [width-1:0] src_a_q;

  logic [width-1:0] abs_a;
  logic [width-1:0] abs_b;

  logic [2*width-1:0] prod_signed;
  logic [2*width-1:0] prod_unsigned;

  logic             core_start;
  logic             core_step;
  logic             core_done;
  logic [width-1:0] core_quotient;
  logic [width-1:0] core_remainder;

  logic [width-1:0] fixed_quotient;
  logic [width-1:0] fixed_remainder;

  assign accept        = (state_q == ST_IDLE) && start && !cancel;
  assign is_div_op     = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed_div = (op == OP_DIV);

  // busy is combinational in the accept cycle so the instruction behind
  // the DIV is held off before the FSM has even left IDLE.
  assign busy = (state_q == ST_RUN) || (accept && is_div_op);

  // Signed division works on magnitudes; the most negative value maps onto
  // itself, which as an unsigned magnitude is still correct.
  assign abs_a = (is_signed_div && src_a[width-1]) ? (~src_a + width'(1)) : src_a;
  assign abs_b = (is_signed_div && src_b[width-1]) ? (~src_b + width'(1)) : src_b;

  // Full-width products. Sign-extending both operands to 2*width and keeping
  // the low 2*width bits of the product yields the signed result.
  assign prod_signed   = {{width{src_a[width-1]}}, src_a} * {{width{src_b[width-1]}}, src_b};
  assign prod_unsigned = {{width{1'b0}}, src_a} * {{width{1'b0}}, src_b};

  assign core_start = accept && is_div_op;
  assign core_step  = (state_q == ST_RUN) && !cancel;

  md_div_core #(
    .width    (width),
    .CntWidth (CntWidth)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .step      (core_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (core_done),
    .quotient  (core_quotient),
    .remainder (core_remainder)
  );

  assign fixed_quotient  = quo_neg_q ? (~core_quotient + width'(1)) : core_quotient;
  assign fixed_remainder = rem_neg_q ? (~core_remainder + width'(1)) : core_remainder;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only honoured in IDLE, so a stalled DIV that
  // is still presenting start during RUN and FIX cannot launch a second
  // division. cancel always returns the FSM to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_div_op) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (core_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Division context latched on acceptance. The raw src_a is kept for the
  // divide-by-zero result, which bypasses the magnitude path entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      src_a_q    <= '0;
    end else if (core_start) begin
      quo_neg_q  <= is_signed_div && (src_a[width-1] ^ src_b[width-1]);
      rem_neg_q  <= is_signed_div && src_a[width-1];
      div_zero_q <= (src_b == '0);
      src_a_q    <= src_a;
    end
  end

  // HI/LO registers. Single-cycle ops write at the end of the accept cycle;
  // divisions write at the end of FIX unless cancelled there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      case (op)
        OP_MULT: begin
          hi <= prod_signed[2*width-1:width];
          lo <= prod_signed[width-1:0];
        end
        OP_MULTU: begin
          hi <= prod_unsigned[2*width-1:width];
          lo <= prod_unsigned[width-1:0];
        end
        OP_MTHI: hi <= src_a;
        OP_MTLO: lo <= src_a;
        default: begin
          hi <= hi;
          lo <= lo;
        end
      endcase
    end else if ((state_q == ST_FIX) && !cancel) begin
      if (div_zero_q) begin
        hi <= src_a_q;
        lo <= '1;
      end else begin
        hi <= fixed_remainder;
        lo <= fixed_quotient;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Self-checking bench for md_unit: a directed vector table, hand-written
// sequences for held start, cancel and reset, and randomized operations
// checked against an arithmetic reference model of HI/LO.
// ---------------------------------------------------------------------------
module tb_md_unit;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam int DIV_BUSY = 33;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy_cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  md_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: HI/LO after an operation, from plain arithmetic.
  function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    longint      q;
    longint      r;
    case (o)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(sp);
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      MULTU: begin
        up = 64'(a) * 64'(b);
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      DIV, DIVU: begin
        if (b == 32'd0) begin
          exp_hi = a;
          exp_lo = 32'hFFFF_FFFF;
        end else if (o == DIV) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          exp_lo = 32'(q);
          exp_hi = 32'(r);
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      MTHI: exp_hi = a;
      MTLO: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Presents one operation starting just after a rising edge, counts the
  // cycles in which busy is high, and returns at the start of the first
  // cycle in which the result must be visible.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input bit hold, output int busy_cycles);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    busy_cycles = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busy_cycles++;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          bc;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{MULT,  32'hFFFF_FFFF, 32'h0000_0002, 0,        32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_BUSY, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{DIVU,  32'd100,       32'd7,         DIV_BUSY, 32'h0000_0002, 32'h0000_000E};
    vecs[5]  = '{DIVU,  32'd5,         32'd0,         DIV_BUSY, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[6]  = '{MTHI,  32'hDEAD_BEEF, 32'h1234_5678, 0,        32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vecs[7]  = '{MTLO,  32'hCAFE_F00D, 32'h0000_0000, 0,        32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[8]  = '{DIV,   32'hFFFF_FFEC, 32'h0000_0000, DIV_BUSY, 32'hFFFF_FFEC, 32'hFFFF_FFFF};
    vecs[9]  = '{DIV,   32'd1000,      32'hFFFF_FFFD, DIV_BUSY, 32'h0000_0001, 32'hFFFF_FEB3};
    vecs[10] = '{3'b110, 32'h1111_1111, 32'h2222_2222, 0,       32'h0000_0001, 32'hFFFF_FEB3};

    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 3'b000;
    src_a  = '0;
    src_b  = '0;
    cancel = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    #12;
    check_output("reset_hi", hi, 32'h0);
    check_output("reset_lo", lo, 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, applied back to back: each op starts in the cycle
    // right after the previous one completed.
    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, bc);
      check_count($sformatf("vec%0d_busy", i), bc, vecs[i].busy_cycles);
      check_output($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check_output($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end
    exp_hi = 32'h0000_0001;
    exp_lo = 32'hFFFF_FEB3;

    // Held start: DIV stays on start through RUN and FIX.
    $display("[TB] held start");
    apply_stimulus(DIVU, 32'd100, 32'd7, 1'b1, bc);
    check_count("held_busy", bc, DIV_BUSY);
    check_output("held_hi", hi, 32'h2);
    check_output("held_lo", lo, 32'hE);
    @(negedge clk);
    check_output("held_no_second_div", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_output("held_hi_stable", hi, 32'h2);
    check_output("held_lo_stable", lo, 32'hE);

    // Cancel at RUN step 10.
    $display("[TB] cancel");
    apply_stimulus(MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0, bc);
    apply_stimulus(MTLO, 32'h5A5A_5A5A, 32'h0, 1'b0, bc);
    start = 1'b1;
    op    = DIV;
    src_a = 32'd12345;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    check_output("cancel_cycle_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    check_output("cancel_next_busy", 32'(busy), 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check_output("cancel_hi", hi, 32'hA5A5_A5A5);
    check_output("cancel_lo", lo, 32'h5A5A_5A5A);

    // Cancel in the accept cycle of MTHI and DIV.
    start  = 1'b1;
    op     = MTHI;
    src_a  = 32'h1111_1111;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    op = DIV;
    src_b = 32'd3;
    @(negedge clk);
    check_output("cancel_div_accept_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    @(negedge clk);
    check_output("cancel_div_idle_busy", 32'(busy), 32'h0);
    check_output("cancel_mthi_hi", hi, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    exp_hi = 32'hA5A5_A5A5;
    exp_lo = 32'h5A5A_5A5A;

    // Randomized operations against the reference model.
    $display("[TB] random");
    for (int n = 0; n < 150; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rand_val();
      rb = rand_val();
      model_op(ro, ra, rb);
      apply_stimulus(ro, ra, rb, 1'($urandom_range(0, 1)), bc);
      check_count($sformatf("rand%0d_busy op=%0d", n, ro), bc,
                  ((ro == DIV) || (ro == DIVU)) ? DIV_BUSY : 0);
      check_output($sformatf("rand%0d_hi op=%0d a=%h b=%h", n, ro, ra, rb), hi, exp_hi);
      check_output($sformatf("rand%0d_lo op=%0d a=%h b=%h", n, ro, ra, rb), lo, exp_lo);
    end

    // Reset in the middle of a division.
    $display("[TB] reset mid-run");
    start = 1'b1;
    op    = DIV;
    src_a = 32'hFFFF_0000;
    src_b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_hi", hi, 32'h0);
    check_output("midrst_lo", lo, 32'h0);
    check_output("midrst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(MTLO, 32'h1234_5678, 32'h0, 1'b0, bc);
    check_count("post_rst_busy", bc, 0);
    check_output("post_rst_lo", lo, 32'h1234_5678);
    check_output("post_rst_hi", hi, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX directly downstream of the ID-stage register file. Consumes the rs/rt read data forwarded through ID/EX. Executes MULT/MULTU in one cycle, DIV/DIVU iteratively, and MTHI/MTLO immediately. Drives the pipeline stall while a division is in flight and presents HI/LO to the MFHI/MFLO path.

## Interface
- `width`, 32, operand / HI / LO width.
- `CntWidth`, 5, iteration counter width; must hold `width - 1`.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: a valid MD instruction is in EX this cycle.
- `op` in 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- `src_a` in `width`: rs value (dividend, multiplicand, MT source).
- `src_b` in `width`: rt value (divisor, multiplier).
- `cancel` in 1: exception flush. Aborts any in-flight or newly presented operation.
- `busy` out 1: stall request to the hazard unit.
- `hi` out `width`: HI register.
- `lo` out `width`: LO register.

## Operation
- **Reset:** `hi` = 0, `lo` = 0, `busy` = 0, state IDLE, counter 0. Reset takes effect immediately, including in the middle of a division.
- **Acceptance:** `start` is accepted only in IDLE with `cancel` = 0.
  - `start` in RUN or FIX is ignored.
  - FIX is the cycle in which the stalled DIV itself is still presenting `start`; ignoring it prevents a second division.
- **MULT / MULTU:** full 2·`width` product, signed or unsigned. `{hi, lo}` is written at the end of the accept cycle. No busy.
- **MTHI / MTLO:** `src_a` is written into `hi` or `lo` at the end of the accept cycle. The other register is unchanged.
- **DIV / DIVU, on accept:**
  - Latch the divisor and dividend. For DIV, latch their magnitudes.
  - Latch the quotient sign (`src_a` MSB xor `src_b` MSB) and the remainder sign (`src_a` MSB) for DIV.
  - Latch a divisor-zero flag.
  - Go to RUN with the counter at 0.
- **RUN:** one restoring shift-subtract step per cycle, producing one quotient bit per cycle MSB-first. After step `width - 1`, go to FIX.
- **FIX, signed correction (DIV):** negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
- **FIX, write-back:** `lo` = quotient, `hi` = remainder at the end of the FIX cycle, then return to IDLE.
- **Divisor zero:** in FIX, `hi` = `src_a` as latched and `lo` = all ones. No sign correction.
- **Overflow:** signed 0x80000000 / -1 gives `lo` = 0x80000000 and `hi` = 0, with no special casing.
- **Cancel:** in any state, the next edge forces IDLE. HI/LO are not written. Cancel in the accept cycle suppresses MULT/MT writes as well.

## Timing
- `busy` = (state == RUN) | (IDLE & `start` & op ∈ {DIV, DIVU} & !`cancel`). It is combinational in the accept cycle so the pipeline holds.
- For a DIV accepted in cycle N:
  - `busy` is high in cycles N … N+`width` (33 cycles at the default width).
  - FIX is cycle N+`width`+1, with `busy` = 0.
  - New HI/LO is visible from cycle N+`width`+2.
  - An MFHI/MFLO that enters EX right behind the DIV reads the correct value.
- MULT/MT results are visible in cycle N+1.
- A new DIV or MULT is accepted in the cycle immediately after FIX.
- `cancel` during RUN: `busy` = 0 from the next cycle.

## Structure
- A shared package/header, `md_defs`, holds:
  - the op encodings (000–101);
  - the state encodings IDLE, RUN and FIX;
  - the `width` and `CntWidth` defaults.
- Sub-module `md_div_core` holds the iterative restoring divider datapath: remainder/quotient shift registers, subtractor and counter. It has a start/done interface.
- The top level holds the FSM, the sign pre/post-processing, the multiplier and the HI/LO registers.

## Test plan
- **MULT / MULTU:** MULT 0xFFFFFFFF × 0x00000002 → `hi` = FFFFFFFF, `lo` = FFFFFFFE next cycle, `busy` never high. MULTU with the same operands → `hi` = 00000001, `lo` = FFFFFFFE.
- **Signed DIV and busy length:** DIV −7 / 2 → `busy` high exactly 33 cycles, then `lo` = FFFFFFFD, `hi` = FFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo` = 80000000, `hi` = 0.
- **Unsigned DIV and divisor zero:** DIVU 100 / 7 → `lo` = 0000000E, `hi` = 00000002. DIVU 5 / 0 → `hi` = 00000005, `lo` = FFFFFFFF.
- **Held start and back-to-back:** `start` held high with DIV through the whole division, including FIX → exactly one division occurs and HI/LO are written once. A DIV presented in the cycle after FIX is accepted.
- **Cancel:** `cancel` at RUN step 10 → `busy` = 0 next cycle and HI/LO keep their prior values. MTHI with `cancel` = 1 → `hi` unchanged.
- **Reset mid-operation:** `rst_n` low mid-RUN → `hi` = `lo` = 0 and `busy` = 0 immediately. After release, MTLO 0x12345678 → `lo` = 12345678 next cycle.
